// File: rtl/ttc3_dus_prov_pkg.sv
// Shared types and constants for the DUS provisioning writer.
// Holds the FSM state encoding, CRC-8 parameters and the default ack window.
package ttc3_dus_prov_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT,
    S_WAIT_ACK,
    S_LOCKED,
    S_DRAIN
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam int DEFAULT_ACK_TIMEOUT = 4;

endpackage

// File: rtl/ttc3_crc8_byte.sv
// Combinational CRC-8 step (MSB-first): next CRC from current CRC and one byte.
// Used by ttc3_dus_provisioner only when TTC3_DUS_PROV_CRC_EN is defined.
module ttc3_crc8_byte
  import ttc3_dus_prov_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/ttc3_dus_provisioner.sv
// Byte-serial DUS frame collector issuing a single write strobe, then locking out; one byte/cycle, ready low outside IDLE/COLLECT/DRAIN.
// Optional trailing CRC-8 frame check is compiled in with TTC3_DUS_PROV_CRC_EN.
module ttc3_dus_provisioner
  import ttc3_dus_prov_pkg::*;
#(
  parameter int DUS_WIDTH   = 256,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 prov_valid,
  input  logic [7:0]           prov_data,
  input  logic                 prov_last,
  output logic                 prov_ready,
  output logic                 prov_done,
  output logic                 prov_error,
  output logic                 busy,
  input  logic                 dus_valid,
  output logic                 write_enable,
  output logic [DUS_WIDTH-1:0] write_data
);

  localparam int NBYTES = DUS_WIDTH / 8;
`ifdef TTC3_DUS_PROV_CRC_EN
  localparam int FLEN = NBYTES + 1;
`else
  localparam int FLEN = NBYTES;
`endif
  localparam int CW = $clog2(FLEN + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] FLEN_C   = CW'(FLEN);
  localparam logic [CW-1:0] NBYTES_C = CW'(NBYTES);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [DUS_WIDTH-1:0]   frame_q, frame_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   accept, scrub;

`ifdef TTC3_DUS_PROV_CRC_EN
  logic [7:0] crc_q, crc_d, crc_nxt;

  ttc3_crc8_byte u_crc (
    .crc_in  (crc_q),
    .data_in (prov_data),
    .crc_out (crc_nxt)
  );
`endif

  // Reset gates every strobe so nothing leaks while reset_n is low.
  assign prov_ready   = reset_n && ((state_q == S_IDLE && !dus_valid) ||
                                    state_q == S_COLLECT || state_q == S_DRAIN);
  assign write_enable = reset_n && (state_q == S_COMMIT);
  assign write_data   = write_enable ? frame_q : '0;
  assign busy         = reset_n && (state_q == S_COLLECT || state_q == S_COMMIT ||
                                    state_q == S_WAIT_ACK);
  assign prov_done    = done_q;
  assign prov_error   = err_q;
  assign accept       = prov_valid && prov_ready;
  assign cnt_inc      = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    scrub   = 1'b0;
`ifdef TTC3_DUS_PROV_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (dus_valid) begin
          if (state_q == S_COLLECT) err_d = 1'b1;
          scrub   = 1'b1;
          state_d = S_LOCKED;
        end else if (accept) begin
          if (state_q == S_IDLE) err_d = 1'b0;
          state_d = S_COLLECT;
          cnt_d   = cnt_inc;
          if (cnt_q < NBYTES_C) begin
            frame_d = {frame_q[DUS_WIDTH-9:0], prov_data};
`ifdef TTC3_DUS_PROV_CRC_EN
            crc_d   = crc_nxt;
`endif
          end
          if (prov_last && cnt_inc == FLEN_C) begin
`ifdef TTC3_DUS_PROV_CRC_EN
            if (prov_data != crc_q) begin
              err_d   = 1'b1;
              scrub   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_COMMIT;
            end
`else
            state_d = S_COMMIT;
`endif
          end else if (prov_last) begin
            err_d   = 1'b1;
            scrub   = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_inc == FLEN_C) begin
            err_d   = 1'b1;
            scrub   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (dus_valid) begin
          err_d   = 1'b1;
          state_d = S_LOCKED;
        end else if (accept && prov_last) begin
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        // Ack window counts from the write-strobe cycle itself.
        scrub   = 1'b1;
        tmr_d   = TW'(1);
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (dus_valid) begin
          done_d  = 1'b1;
          state_d = S_LOCKED;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_LOCKED: begin
        if (prov_valid) err_d = 1'b1;
      end
      default: begin
        scrub   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    if (scrub) begin
      frame_d = '0;
      cnt_d   = '0;
`ifdef TTC3_DUS_PROV_CRC_EN
      crc_d   = CRC8_INIT;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef TTC3_DUS_PROV_CRC_EN
      crc_q   <= CRC8_INIT;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef TTC3_DUS_PROV_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_ttc3_dus_provisioner.sv
// Directed bench for ttc3_dus_provisioner: frame scenario table plus timing/reset sequences.
// A small storage model raises dus_valid one edge after it sees write_enable when enabled.
module tb_ttc3_dus_provisioner;

  localparam int NB = 32;
`ifdef TTC3_DUS_PROV_CRC_EN
  localparam int FLEN = NB + 1;
`else
  localparam int FLEN = NB;
`endif
  localparam logic [255:0] EXP = {4{64'hDEADBEEF_CAFEBABE}};

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         prov_valid = 1'b0;
  logic [7:0]   prov_data = 8'h00;
  logic         prov_last = 1'b0;
  logic         prov_ready, prov_done, prov_error, busy;
  logic         dus_valid;
  logic         write_enable;
  logic [255:0] write_data;

  logic model_en = 1'b0;
  logic store_clr = 1'b1;
  logic force_dv = 1'b0;
  logic stored = 1'b0;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int leak = 0;
  logic [255:0] wd_cap = '0;

  ttc3_dus_provisioner dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .prov_valid   (prov_valid),
    .prov_data    (prov_data),
    .prov_last    (prov_last),
    .prov_ready   (prov_ready),
    .prov_done    (prov_done),
    .prov_error   (prov_error),
    .busy         (busy),
    .dus_valid    (dus_valid),
    .write_enable (write_enable),
    .write_data   (write_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (store_clr) stored <= 1'b0;
    else if (model_en && write_enable) stored <= 1'b1;
  end
  assign dus_valid = stored | force_dv;

  always @(negedge clock) begin
    if (write_enable) begin
      we_cnt = we_cnt + 1;
      wd_cap = write_data;
    end else if (write_data != '0) begin
      leak = leak + 1;
    end
  end

  typedef struct {
    bit           rst;
    bit           model;
    int           n;
    bit           last;
    int           pat;
    bit           bad;
    bit           e1;
    bit           err;
    int           we;
    logic [255:0] wd;
    bit           locked;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int i, input int pat);
    if (pat != 0) return 8'h00;
    case (i % 8)
      0: return 8'hDE;
      1: return 8'hAD;
      2: return 8'hBE;
      3: return 8'hEF;
      4: return 8'hCA;
      5: return 8'hFE;
      6: return 8'hBA;
      default: return 8'hBE;
    endcase
  endfunction

`ifdef TTC3_DUS_PROV_CRC_EN
  function automatic logic [7:0] crc_of(input int pat);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < NB; i++) begin
      c = c ^ pat_byte(i, pat);
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  task automatic send_frame(input int n, input bit last, input int pat, input bit bad,
                            output bit e1);
    logic [7:0] b;
    e1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = pat_byte(i, pat);
`ifdef TTC3_DUS_PROV_CRC_EN
      if (i == NB) b = crc_of(pat) ^ {7'd0, bad};
`else
      if (bad && i == n - 1) b = ~b;
`endif
      prov_valid = 1'b1;
      prov_data  = b;
      prov_last  = last && (i == n - 1);
      tick();
      if (i == 0) e1 = prov_error;
    end
    prov_valid = 1'b0;
    prov_last  = 1'b0;
    prov_data  = 8'h00;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    store_clr = 1'b1;
    force_dv  = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
    store_clr = 1'b0;
  endtask

  task automatic add(input bit rst, input bit model, input int n, input bit last, input int pat,
                     input bit bad, input bit e1, input bit err, input int we,
                     input logic [255:0] wd, input bit locked);
    vec_t v;
    v.rst = rst; v.model = model; v.n = n; v.last = last; v.pat = pat; v.bad = bad;
    v.e1 = e1; v.err = err; v.we = we; v.wd = wd; v.locked = locked;
    vecs.push_back(v);
  endtask

  initial begin
    bit e1;
    int w0;

    add(1, 1, FLEN,     1, 0, 0, 0, 0, 1, EXP, 1);
    add(0, 1, FLEN,     1, 0, 0, 1, 1, 0, '0,  1);
    add(1, 1, 10,       1, 0, 0, 0, 1, 0, '0,  0);
    add(0, 1, FLEN,     1, 0, 0, 0, 0, 1, EXP, 1);
    add(1, 1, FLEN + 1, 0, 0, 0, 0, 1, 0, '0,  0);
    add(0, 1, 3,        1, 0, 0, 1, 1, 0, '0,  0);
    add(0, 1, FLEN,     1, 0, 0, 0, 0, 1, EXP, 1);
    add(1, 0, FLEN,     1, 0, 0, 0, 1, 1, EXP, 0);
`ifdef TTC3_DUS_PROV_CRC_EN
    add(1, 1, FLEN,     1, 1, 1, 0, 1, 0, '0,  0);
    add(1, 1, FLEN,     1, 1, 0, 0, 0, 1, '0,  1);
`endif

    // Reset state, sampled while reset is still asserted
    tick();
    chk("rst_ready", prov_ready, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_wd", write_data, 0);
    chk("rst_done", prov_done, 0);
    chk("rst_err", prov_error, 0);
    chk("rst_busy", busy, 0);
    reset_n   = 1'b1;
    store_clr = 1'b0;
    #1;
    chk("idle_ready", prov_ready, 1);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      model_en = vecs[k].model;
      w0 = we_cnt;
      send_frame(vecs[k].n, vecs[k].last, vecs[k].pat, vecs[k].bad, e1);
      repeat (8) tick();
      chk($sformatf("v%0d_err_first", k), e1, vecs[k].e1);
      chk($sformatf("v%0d_err", k), prov_error, vecs[k].err);
      chk($sformatf("v%0d_writes", k), we_cnt - w0, vecs[k].we);
      if (vecs[k].we > 0) chk($sformatf("v%0d_wdata", k), wd_cap, vecs[k].wd);
      chk($sformatf("v%0d_ready", k), prov_ready, !vecs[k].locked);
      chk($sformatf("v%0d_busy", k), busy, 0);
    end

    // Commit timing: strobe right after last byte, done two cycles later
    do_reset();
    model_en = 1'b1;
    send_frame(FLEN, 1, 0, 0, e1);
    chk("t_we", write_enable, 1);
    chk("t_wd", write_data, EXP);
    chk("t_busy", busy, 1);
    chk("t_ready", prov_ready, 0);
    tick();
    chk("t_we_off", write_enable, 0);
    chk("t_wd_off", write_data, 0);
    chk("t_done_early", prov_done, 0);
    tick();
    chk("t_done", prov_done, 1);
    chk("t_busy_locked", busy, 0);
    tick();
    chk("t_done_pulse", prov_done, 0);

    // No ack: error 4 cycles after the strobe
    do_reset();
    model_en = 1'b0;
    send_frame(FLEN, 1, 0, 0, e1);
    chk("to_we", write_enable, 1);
    repeat (3) tick();
    chk("to_err_early", prov_error, 0);
    tick();
    chk("to_err", prov_error, 1);
    chk("to_ready", prov_ready, 1);
    chk("to_done", prov_done, 0);

    // Reset mid-frame, then a full frame must still land intact
    do_reset();
    model_en = 1'b1;
    w0 = we_cnt;
    send_frame(20, 0, 0, 0, e1);
    reset_n = 1'b0;
    tick();
    chk("mr_ready", prov_ready, 0);
    chk("mr_we", write_enable, 0);
    chk("mr_wd", write_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_err", prov_error, 0);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("mr_nowrite", we_cnt - w0, 0);
    send_frame(FLEN, 1, 0, 0, e1);
    repeat (6) tick();
    chk("mr_writes", we_cnt - w0, 1);
    chk("mr_wdata", wd_cap, EXP);
    chk("mr_err_after", prov_error, 0);

    // dus_valid held through reset: lock without any frame
    reset_n  = 1'b0;
    force_dv = 1'b1;
    store_clr = 1'b1;
    tick();
    tick();
    reset_n   = 1'b1;
    store_clr = 1'b0;
    tick();
    force_dv = 1'b0;
    tick();
    chk("dv_locked_ready", prov_ready, 0);
    chk("dv_locked_busy", busy, 0);
    prov_valid = 1'b1;
    tick();
    prov_valid = 1'b0;
    chk("dv_locked_err", prov_error, 1);

    // dus_valid appearing mid-frame
    do_reset();
    model_en = 1'b0;
    w0 = we_cnt;
    send_frame(5, 0, 0, 0, e1);
    force_dv = 1'b1;
    tick();
    force_dv = 1'b0;
    chk("cv_err", prov_error, 1);
    tick();
    chk("cv_ready", prov_ready, 0);
    chk("cv_nowrite", we_cnt - w0, 0);

    chk("wdata_leak", leak, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttc3_dus_provisioner.md
# ttc3_dus_provisioner

Provisioning-side writer for the Device Unique Secret (DUS) store. Accepts a byte-serial DUS frame from the manufacturing provisioning port and assembles it into a full-width secret. When the optional integrity check is compiled in, it verifies the frame. It then issues exactly one write-enable pulse to the DUS storage block and confirms the commit via the storage's `dus_valid`. After that it locks out all further provisioning, and secret material is never left on its output bus.

## Interface
- `DUS_WIDTH`, 256, secret width in bits; must be a multiple of 8; `NBYTES = DUS_WIDTH/8`.
- `ACK_TIMEOUT`, 4, cycles to wait for `dus_valid` after the write pulse.

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `prov_valid`  in  1  provisioning byte strobe.
- `prov_data`  in  8  provisioning byte.
- `prov_last`  in  1  marks the final byte of a frame; qualified by `prov_valid`.
- `prov_ready`  out  1  byte accepted on an edge where `prov_valid && prov_ready`.
- `prov_done`  out  1  one-cycle pulse: DUS committed and acknowledged.
- `prov_error`  out  1  sticky error flag.
- `busy`  out  1  high in COLLECT, COMMIT and WAIT_ACK.
- `dus_valid`  in  1  from DUS storage: the secret is programmed.
- `write_enable`  out  1  one-cycle write strobe to storage.
- `write_data`  out  DUS_WIDTH  secret to storage; zero whenever `write_enable` = 0.

## Operation
- States: IDLE, COLLECT, COMMIT, WAIT_ACK, LOCKED, DRAIN.
- Reset: `write_enable`, `write_data`, `prov_done`, `prov_error` and `busy` = 0; `prov_ready` = 0 during reset. The byte buffer, byte counter and CRC are cleared. The state is IDLE.
- In IDLE, if `dus_valid` = 1, go to LOCKED. Otherwise `prov_ready` = 1.
- First accepted byte: clears `prov_error` and enters COLLECT.
- Byte assembly: the buffer shifts left by 8 and each new byte fills the LSBs, so the first byte lands in `[DUS_WIDTH-1 -: 8]`.
- Frame length is `FLEN = NBYTES`, or `NBYTES+1` with the CRC feature.
- `prov_last` on byte `FLEN`: the frame is complete, and the next state is COMMIT. With the CRC feature, a CRC mismatch instead sets the error and the next state is IDLE.
- `prov_last` before byte `FLEN`: set `prov_error`, clear the buffer, go to IDLE.
- Byte `FLEN` accepted without `prov_last`: set `prov_error`, clear the buffer, go to DRAIN.
- DRAIN: `prov_ready` = 1 and bytes are discarded until a `prov_last` byte is accepted, then go to IDLE.
- `dus_valid` rising while in COLLECT or DRAIN: set `prov_error`, clear the buffer, go to LOCKED.
- COMMIT: lasts one cycle with `write_enable` = 1 and `write_data` = buffer. Go to WAIT_ACK and clear the buffer on the same edge.
- WAIT_ACK: if `dus_valid` is seen, pulse `prov_done` next cycle and go to LOCKED. If there is no `dus_valid` within `ACK_TIMEOUT` cycles, set `prov_error` and go to IDLE.
- LOCKED: `prov_ready` = 0. Any `prov_valid` sets `prov_error`. Only reset exits this state.

## Timing
- Byte acceptance takes effect at the edge where `prov_valid && prov_ready`. There is one byte per cycle at most.
- Last byte accepted at edge E: `write_enable` is high in the cycle after E. The storage raises `dus_valid` after the following edge. `prov_done` is high one cycle after `dus_valid` is first sampled in WAIT_ACK.
- `prov_ready` = 0 in COMMIT, WAIT_ACK and LOCKED.
- Reset asserted mid-frame or in WAIT_ACK: next cycle all outputs are 0 and the buffer is zeroed. No partial write is ever issued.

## Configuration
- `TTC3_DUS_PROV_CRC_EN` defined: each frame carries a trailing CRC-8 byte (poly 0x07, init 0x00, MSB-first) computed over the `NBYTES` data bytes.
  - CRC mismatch: `prov_error` is set and no write is issued.
- Not defined: frame is `NBYTES` bytes only, no CRC logic is present, and a length-correct frame always commits.

## Structure
- Package `ttc3_dus_prov_pkg` holds:
  - the state enum;
  - `CRC8_POLY` and `CRC8_INIT`;
  - the default `ACK_TIMEOUT`.
- Sub-module `ttc3_crc8_byte`: combinational next-CRC given the current CRC and a byte. It is instantiated only under `TTC3_DUS_PROV_CRC_EN`. The CRC register itself lives in the parent.

## Test plan
- 32 bytes `DE AD BE EF CA FE BA BE ...` + `prov_last` (plus correct CRC if enabled), with storage model:
  - one `write_enable` pulse with `write_data` = `256'hDEADBEEF_CAFEBABE_...`;
  - `write_data` = 0 before and after;
  - `prov_done` pulse, then LOCKED.
- Second frame after a successful commit: `prov_ready` = 0, `prov_error` = 1, and no further `write_enable`.
- `prov_last` on byte 10: `prov_error` = 1, no write. A following correct frame then commits and clears `prov_error` at its first byte.
- 33 data bytes without `prov_last` (CRC off): error at byte 32, DRAIN until `prov_last`, then IDLE, no write.
- CRC enabled, 32 zero bytes with CRC byte 0x01 (correct CRC is 0x00): `prov_error` = 1, no write. With CRC 0x00: commit with `write_data` = 0.
- Storage model never raises `dus_valid`: `prov_error` is set 4 cycles after `write_enable`.
- Reset pulse at byte 20: all outputs 0 the next cycle and no write. `dus_valid` high at reset: state goes to LOCKED.
